// File: rtl/des_keysearch_ctrl.sv
// des_keysearch_ctrl: walks an inclusive 56-bit key range into a pipelined DES engine and records the first key whose result matches the target
module des_keysearch_ctrl #(
  parameter int KEY_W = 56,
  parameter int BLK_W = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] start_key,
  input  logic [KEY_W-1:0] end_key,
  input  logic [BLK_W-1:0] target,
  input  logic             abort,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [BLK_W-1:0] key_out,
  input  logic             res_valid,
  input  logic [BLK_W-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [KEY_W-1:0] found_key,
  output logic [KEY_W-1:0] keys_tried
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [KEY_W-1:0] r_next_key, r_end_key, r_found_key, r_keys_tried;
  logic [BLK_W-1:0] r_target;
  logic [KEY_W-1:0] r_fifo [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt, w_cnt_nxt;
  logic r_last, r_found, w_start, w_issue, w_pop, w_hit, w_last_nxt;
  assign w_start = start && (r_state == IDLE || r_state == DONE);
  // the count never exceeds DEPTH, so its top bit alone means "full"
  assign key_valid = r_state == RUN && !r_last && !r_cnt[AW];
  assign w_issue = key_valid && key_ready;
  assign w_pop = (r_state == RUN || r_state == DRAIN) && res_valid && r_cnt != '0;
  assign w_hit = r_state == RUN && w_pop && res_data == r_target;
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_issue) - (AW+1)'(w_pop);
  assign w_last_nxt = r_last || (w_issue && r_next_key == r_end_key);
  assign busy = r_state == RUN || r_state == DRAIN;
  assign done = r_state == DONE;
  assign found = r_found;
  assign found_key = r_found_key;
  assign keys_tried = r_keys_tried;
  always_comb begin
    key_out = '0;
    for (int i = 0; i < 8; i++) begin
      key_out[8*i+1 +: 7] = r_next_key[7*i +: 7];
      key_out[8*i] = ~^r_next_key[7*i +: 7];
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: w_state_nxt = w_start ? RUN : r_state;
      RUN: w_state_nxt = (w_hit || abort) ? DRAIN : (w_last_nxt && w_cnt_nxt == '0) ? DONE : RUN;
      DRAIN: w_state_nxt = w_cnt_nxt == '0 ? DONE : DRAIN;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (w_issue) r_fifo[r_wp] <= r_next_key;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_key <= '0;
      r_end_key <= '0;
      r_target <= '0;
      r_found <= 1'b0;
      r_found_key <= '0;
      r_keys_tried <= '0;
      r_last <= 1'b0;
      r_cnt <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_issue) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_start) begin
        r_next_key <= start_key;
        r_end_key <= end_key;
        r_target <= target;
        r_found <= 1'b0;
        r_found_key <= '0;
        r_keys_tried <= '0;
        r_last <= 1'b0;
      end else begin
        if (w_issue) begin
          r_last <= w_last_nxt;
          r_next_key <= r_next_key == r_end_key ? r_next_key : r_next_key + KEY_W'(1);
        end
        if (w_pop && r_state == RUN) r_keys_tried <= r_keys_tried + KEY_W'(1);
        if (w_hit) begin
          r_found <= 1'b1;
          r_found_key <= r_fifo[r_rp];
        end
      end
    end
  end
endmodule
